// File: rtl/neural_soc_pkg.sv
// neural_soc_pkg: shared FSM state type and system ID slave word addresses
package neural_soc_pkg;
    typedef enum logic [2:0] {IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, COMPARE, PASS, FAIL} sysid_state_t;
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
endpackage

// File: rtl/neural_soc_avm_read_timer.sv
// neural_soc_avm_read_timer: per-transaction timeout counter and retry counter
module neural_soc_avm_read_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic tx_clr,
    input  logic tx_run,
    input  logic rt_clr,
    input  logic rt_inc,
    output logic expired,
    output logic exhausted
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam int RW = $clog2(MAX_RETRIES + 2);
    logic [CW-1:0] cnt;
    logic [RW-1:0] retries;
    always_ff @(posedge clock) begin
        if (reset || tx_clr) cnt <= '0;
        else if (tx_run && cnt != '1) cnt <= cnt + CW'(1);
        if (reset || rt_clr) retries <= '0;
        else if (rt_inc) retries <= retries + RW'(1);
    end
    assign expired = int'(cnt) >= TIMEOUT_CYCLES - 1;
    assign exhausted = int'(retries) >= MAX_RETRIES;
endmodule

// File: rtl/neural_soc_sysid_checker.sv
// neural_soc_sysid_checker: boot-time system ID check gating accel_enable.
// SYSID_CHECK_TIMESTAMP_EN adds the build timestamp read and compare.
module neural_soc_sysid_checker
    import neural_soc_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1480974486,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        check_done,
    output logic        check_pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout_err,
    output logic        accel_enable,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);
    sysid_state_t state, nxt;
    logic auto_start, launch, is_req, is_wait, accept, data, expire, retry, enter_req;
    logic id_bad, ts_bad, expired, exhausted;

`ifdef SYSID_CHECK_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
    always_ff @(posedge clock) begin
        if (reset) begin
            captured_ts <= '0;
            ts_mismatch <= 1'b0;
        end else begin
            if (data && state == TS_WAIT) captured_ts <= avm_readdata;
            ts_mismatch <= launch ? 1'b0 : state == COMPARE ? ts_bad : ts_mismatch;
        end
    end
`else
    localparam bit TS_EN = 1'b0;
    assign captured_ts = '0;
    assign ts_mismatch = 1'b0;
`endif

    neural_soc_avm_read_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRIES(MAX_RETRIES)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .tx_clr(enter_req),
        .tx_run(is_req || is_wait),
        .rt_clr(launch),
        .rt_inc(retry),
        .expired(expired),
        .exhausted(exhausted)
    );

    always_comb begin
        is_req = state == ID_REQ || state == TS_REQ;
        is_wait = state == ID_WAIT || state == TS_WAIT;
        accept = is_req && avm_read && !avm_waitrequest;
        data = is_wait && avm_readdatavalid;
        // progress (acceptance or data) wins over a coincident timeout
        expire = (is_req || is_wait) && expired && !accept && !data;
        retry = expire && !exhausted;
        launch = (state == IDLE || state == PASS || state == FAIL) && (start || auto_start);
        id_bad = captured_id != EXPECTED_ID;
        ts_bad = TS_EN && captured_ts != EXPECTED_TIMESTAMP;
        nxt = state;
        case (state)
            IDLE, PASS, FAIL: nxt = launch ? ID_REQ : state;
            ID_REQ:  nxt = accept ? ID_WAIT : ID_REQ;
            ID_WAIT: nxt = data ? (TS_EN ? TS_REQ : COMPARE) : ID_WAIT;
            TS_REQ:  nxt = accept ? TS_WAIT : TS_REQ;
            TS_WAIT: nxt = data ? COMPARE : TS_WAIT;
            COMPARE: nxt = id_bad || ts_bad ? FAIL : PASS;
            default: nxt = IDLE;
        endcase
        if (expire) nxt = !retry ? FAIL : state inside {ID_REQ, ID_WAIT} ? ID_REQ : TS_REQ;
        enter_req = (nxt == ID_REQ || nxt == TS_REQ) && (!is_req || retry);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end

    // outputs are registered from the next state; a retry leaves one idle cycle before re-issuing
    always_ff @(posedge clock) begin
        if (reset) begin
            auto_start <= 1'b1;
            avm_read <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            busy <= 1'b0;
            check_done <= 1'b0;
            check_pass <= 1'b0;
            accel_enable <= 1'b0;
            id_mismatch <= 1'b0;
            timeout_err <= 1'b0;
            captured_id <= '0;
        end else begin
            auto_start <= 1'b0;
            avm_read <= (nxt == ID_REQ || nxt == TS_REQ) && !retry;
            avm_address <= nxt == TS_REQ || nxt == TS_WAIT ? SYSID_ADDR_TS : SYSID_ADDR_ID;
            busy <= !(nxt inside {IDLE, PASS, FAIL});
            check_done <= nxt == PASS || nxt == FAIL;
            check_pass <= nxt == PASS;
            accel_enable <= nxt == PASS;
            if (data && state == ID_WAIT) captured_id <= avm_readdata;
            id_mismatch <= launch ? 1'b0 : state == COMPARE ? id_bad : id_mismatch;
            timeout_err <= launch ? 1'b0 : expire && !retry ? 1'b1 : timeout_err;
        end
    end
endmodule

// File: tb/tb_neural_soc_sysid_checker.sv
// tb_neural_soc_sysid_checker: directed and randomized checks against a behavioural slave and outcome model
module tb_neural_soc_sysid_checker;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1480974486;
    localparam int TO = 8;
    localparam int MR = 3;
    localparam int BOUND = 300;
`ifdef SYSID_CHECK_TIMESTAMP_EN
    localparam int W = 2;
`else
    localparam int W = 1;
`endif

    logic clock = 1'b0, reset, start;
    logic avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic busy, check_done, check_pass, id_mismatch, ts_mismatch, timeout_err, accel_enable;
    logic [31:0] captured_id, captured_ts;

    logic [31:0] slv_id, slv_ts, pend_data, m_id, m_ts;
    int stall_cfg, stalled, drops, accepts, viol, n_checks, n_fail, n;
    bit never, pend, prev_stall;
    logic prev_addr;

    always #5 clock = ~clock;

    neural_soc_sysid_checker #(
        .EXPECTED_ID(EXP_ID),
        .EXPECTED_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRIES(MR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata(avm_readdata),
        .busy(busy),
        .check_done(check_done),
        .check_pass(check_pass),
        .id_mismatch(id_mismatch),
        .ts_mismatch(ts_mismatch),
        .timeout_err(timeout_err),
        .accel_enable(accel_enable),
        .captured_id(captured_id),
        .captured_ts(captured_ts)
    );

    // system ID slave: configurable stall, data one cycle after acceptance, optional dropped ID reads
    initial begin
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata = '0;
        forever begin
            @(negedge clock);
            if (prev_stall && (!avm_read || avm_address != prev_addr)) viol++;
            avm_readdatavalid = pend;
            avm_readdata = pend ? pend_data : 32'hdead_beef;
            pend = 1'b0;
            if (avm_read && stalled < stall_cfg) begin
                avm_waitrequest = 1'b1;
                stalled++;
            end else begin
                avm_waitrequest = 1'b0;
                stalled = 0;
                if (avm_read) begin
                    accepts++;
                    if (never) pend = 1'b0;
                    else if (!avm_address && drops > 0) drops--;
                    else begin
                        pend = 1'b1;
                        pend_data = avm_address ? slv_ts : slv_id;
                    end
                end
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr = avm_address;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string p);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, check_done, 0);
        check({p, "_pass"}, check_pass, 0);
        check({p, "_idmis"}, id_mismatch, 0);
        check({p, "_tsmis"}, ts_mismatch, 0);
        check({p, "_terr"}, timeout_err, 0);
        check({p, "_accel"}, accel_enable, 0);
        check({p, "_read"}, avm_read, 0);
        check({p, "_addr"}, avm_address, 0);
        check({p, "_capid"}, captured_id, 0);
        check({p, "_capts"}, captured_ts, 0);
    endtask

    task automatic wait_done(input int n0, input int poke, output int cyc);
        cyc = n0;
        do begin
            @(negedge clock);
            cyc++;
            start = (cyc == poke);
        end while (!check_done && cyc < BOUND);
        check("done_within_bound", 32'(cyc < BOUND), 1);
    endtask

    function automatic int lat(input int s);
        return 2 + W * (2 + s);
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        slv_id = EXP_ID;
        slv_ts = EXP_TS;
        repeat (3) @(negedge clock);
        check_idle("rst");
        reset = 1'b0;
        wait_done(0, 0, n);
        check("nom_lat", n, lat(0));
        check("nom_pass", check_pass, 1);
        check("nom_accel", accel_enable, 1);
        check("nom_capid", captured_id, EXP_ID);
        check("nom_capts", captured_ts, W == 2 ? EXP_TS : 32'd0);

        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("re_accel_drop", accel_enable, 0);
        check("re_done_clr", check_done, 0);
        check("re_busy", busy, 1);
        wait_done(1, 2, n);
        check("re_lat", n, lat(0));
        check("re_accel", accel_enable, 1);

        slv_id = 32'd5;
        start = 1'b1;
        wait_done(0, 0, n);
        check("idm_flag", id_mismatch, 1);
        check("idm_pass", check_pass, 0);
        check("idm_accel", accel_enable, 0);
        check("idm_capid", captured_id, 5);
        check("idm_tsmis", ts_mismatch, 0);

        slv_id = EXP_ID;
        stall_cfg = 4;
        viol = 0;
        start = 1'b1;
        wait_done(0, 0, n);
        check("wr_lat", n, lat(4));
        check("wr_pass", check_pass, 1);
        check("wr_stable", viol, 0);
        stall_cfg = 0;

        never = 1'b1;
        accepts = 0;
        start = 1'b1;
        wait_done(0, 0, n);
        check("to_reqs", accepts, MR + 1);
        check("to_terr", timeout_err, 1);
        check("to_pass", check_pass, 0);
        check("to_accel", accel_enable, 0);

        never = 1'b0;
        drops = 2;
        accepts = 0;
        start = 1'b1;
        wait_done(0, 0, n);
        check("third_pass", check_pass, 1);
        check("third_terr", timeout_err, 0);
        check("third_reqs", accepts, W + 2);

        never = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("mid_in_wait", {busy, avm_read}, 2'b10);
        reset = 1'b1;
        @(negedge clock);
        check_idle("mid");
        never = 1'b0;
        reset = 1'b0;
        wait_done(0, 0, n);
        check("mid_lat", n, lat(0));
        check("mid_pass", check_pass, 1);

        m_id = EXP_ID;
        m_ts = W == 2 ? EXP_TS : 32'd0;
        for (int t = 0; t < 16; t++) begin
            logic [31:0] id, ts;
            int s, d;
            bit to_exp, ok_exp;
            id = $urandom_range(0, 1) ? EXP_ID : $urandom;
            ts = $urandom_range(0, 1) ? EXP_TS : $urandom;
            s = $urandom_range(0, 3);
            d = $urandom_range(0, 4);
            slv_id = id;
            slv_ts = ts;
            stall_cfg = s;
            drops = d;
            accepts = 0;
            start = 1'b1;
            wait_done(0, 0, n);
            to_exp = d > MR;
            if (!to_exp) begin
                m_id = id;
                if (W == 2) m_ts = ts;
            end
            ok_exp = !to_exp && id == EXP_ID && (W == 1 || ts == EXP_TS);
            check("rnd_pass", check_pass, ok_exp);
            check("rnd_accel", accel_enable, ok_exp);
            check("rnd_terr", timeout_err, to_exp);
            check("rnd_idmis", id_mismatch, !to_exp && id != EXP_ID);
            check("rnd_tsmis", ts_mismatch, !to_exp && W == 2 && ts != EXP_TS);
            check("rnd_capid", captured_id, m_id);
            check("rnd_capts", captured_ts, m_ts);
            check("rnd_reqs", accepts, to_exp ? MR + 1 : W + d);
            if (d == 0) check("rnd_lat", n, lat(s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
